// File: rtl/vector_packer_if.sv
// Bundle of the operand stream, accumulator link and result stream of
// vector_packer. The master modport is the packer's view; the slave modport
// is the view of the surrounding logic (producer, accumulator, consumer).
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised, the sender holds
// it and its data unchanged until that edge. Ready may change freely and
// never waits on valid.
interface vector_packer_if #(
  parameter int WIDTH    = 16,
  parameter int VARWIDTH = 32
);
  logic                      in_valid;
  logic [VARWIDTH-1:0]       in_data;
  logic                      in_last;
  logic                      in_ready;
  logic [VARWIDTH*WIDTH-1:0] vals;
  logic                      acc_rst;
  logic                      acc_en;
  logic                      acc_rdy;
  logic [VARWIDTH-1:0]       acc_sum;
  logic                      out_valid;
  logic [VARWIDTH-1:0]       out_sum;
  logic                      out_ready;
  logic [7:0]                fill_count;
  logic                      err;

  modport master (
    input  in_valid, in_data, in_last, acc_rdy, acc_sum, out_ready,
    output in_ready, vals, acc_rst, acc_en, out_valid, out_sum, fill_count, err
  );

  modport slave (
    output in_valid, in_data, in_last, acc_rdy, acc_sum, out_ready,
    input  in_ready, vals, acc_rst, acc_en, out_valid, out_sum, fill_count, err
  );
endinterface

// File: rtl/vector_packer.sv
// vector_packer: collects serial 32-bit operands into a WIDTH-slot vector,
// runs the tree accumulator once per vector (one clear pulse, then enable
// until the accumulator reports ready) and offers the returned sum on a
// valid/ready output. Short vectors (in_last) are zero padded.
//
// Optional feature: define VECTOR_PACKER_TIMEOUT_EN to add a RUN watchdog.
// If acc_rdy is not seen within TIMEOUT_CYCLES RUN cycles, the sticky err
// flag is set and a zero sum is emitted. Without the macro err is tied to 0
// and RUN waits for acc_rdy indefinitely.
//
// State sequence: FILL -> CLEAR -> RUN -> DRAIN -> FILL. All outputs except
// in_ready are registered; in_ready is high only in FILL. The current state
// is exposed on o_dbg_state.
module vector_packer #(
  parameter int WIDTH          = 16,
  parameter int VARWIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_packer_if.master      bus,
  output logic [1:0]           o_dbg_state
);

  // Parameter sanity: WIDTH must be a power of two in 2..128 so fill_count
  // (8 bits) can hold WIDTH, and the watchdog needs at least one cycle.
  if ((WIDTH < 2) || (WIDTH > 128) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("vector_packer: WIDTH must be a power of two between 2 and 128");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vector_packer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(WIDTH - 1);

  state_t                    r_state,       w_state_nxt;
  logic [VARWIDTH*WIDTH-1:0] r_vals,        w_vals_nxt;
  logic [7:0]                r_fill_count,  w_fill_count_nxt;
  logic                      r_acc_rst,     w_acc_rst_nxt;
  logic                      r_acc_en,      w_acc_en_nxt;
  logic                      r_out_valid,   w_out_valid_nxt;
  logic [VARWIDTH-1:0]       r_out_sum,     w_out_sum_nxt;
  // High during the first RUN cycle, where acc_rdy may still reflect the
  // previous vector and must not be trusted.
  logic                      r_run_first,   w_run_first_nxt;
  logic                      w_vec_done;

`ifdef VECTOR_PACKER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             r_err,     w_err_nxt;
`endif

  // Next-state and next-register decode; every target defaults to hold.
  always_comb begin
    w_state_nxt      = r_state;
    w_vals_nxt       = r_vals;
    w_fill_count_nxt = r_fill_count;
    w_acc_rst_nxt    = r_acc_rst;
    w_acc_en_nxt     = r_acc_en;
    w_out_valid_nxt  = r_out_valid;
    w_out_sum_nxt    = r_out_sum;
    w_run_first_nxt  = r_run_first;
    w_vec_done       = 1'b0;
`ifdef VECTOR_PACKER_TIMEOUT_EN
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_err_nxt        = r_err;
`endif

    case (r_state)
      S_FILL: begin
        w_acc_rst_nxt   = 1'b0;
        w_acc_en_nxt    = 1'b0;
        w_out_valid_nxt = 1'b0;
        if (bus.in_valid) begin
          w_vec_done = bus.in_last || (r_fill_count == LAST_IDX);
          // Write the operand into its slot; on the closing operand also
          // force every higher slot to zero so padding is guaranteed.
          for (int k = 0; k < WIDTH; k++) begin
            if (k == int'(r_fill_count)) begin
              w_vals_nxt[k*VARWIDTH +: VARWIDTH] = bus.in_data;
            end else if (w_vec_done && (k > int'(r_fill_count))) begin
              w_vals_nxt[k*VARWIDTH +: VARWIDTH] = '0;
            end
          end
          w_fill_count_nxt = r_fill_count + 8'd1;
          if (w_vec_done) begin
            w_state_nxt   = S_CLEAR;
            w_acc_rst_nxt = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        // Single clear cycle; enable is raised together with entering RUN.
        w_acc_rst_nxt   = 1'b0;
        w_acc_en_nxt    = 1'b1;
        w_run_first_nxt = 1'b1;
        w_state_nxt     = S_RUN;
`ifdef VECTOR_PACKER_TIMEOUT_EN
        w_tmo_cnt_nxt   = '0;
`endif
      end

      S_RUN: begin
        w_run_first_nxt = 1'b0;
        if (!r_run_first && bus.acc_rdy) begin
          w_out_sum_nxt   = bus.acc_sum;
          w_out_valid_nxt = 1'b1;
          w_acc_en_nxt    = 1'b0;
          w_state_nxt     = S_DRAIN;
        end
`ifdef VECTOR_PACKER_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_err_nxt       = 1'b1;
          w_out_sum_nxt   = '0;
          w_out_valid_nxt = 1'b1;
          w_acc_en_nxt    = 1'b0;
          w_state_nxt     = S_DRAIN;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
`endif
      end

      S_DRAIN: begin
        if (bus.out_ready) begin
          w_out_valid_nxt  = 1'b0;
          w_fill_count_nxt = '0;
          w_vals_nxt       = '0;
          w_state_nxt      = S_FILL;
        end
      end

      default: begin
        // Unreachable encodings fall back to an idle FILL.
        w_state_nxt     = S_FILL;
        w_acc_en_nxt    = 1'b0;
        w_acc_rst_nxt   = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FILL;
      r_vals       <= '0;
      r_fill_count <= '0;
      r_acc_rst    <= 1'b1;
      r_acc_en     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_run_first  <= 1'b0;
`ifdef VECTOR_PACKER_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_vals       <= w_vals_nxt;
      r_fill_count <= w_fill_count_nxt;
      r_acc_rst    <= w_acc_rst_nxt;
      r_acc_en     <= w_acc_en_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_sum    <= w_out_sum_nxt;
      r_run_first  <= w_run_first_nxt;
`ifdef VECTOR_PACKER_TIMEOUT_EN
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_err        <= w_err_nxt;
`endif
    end
  end

  assign bus.in_ready   = (r_state == S_FILL);
  assign bus.vals       = r_vals;
  assign bus.fill_count = r_fill_count;
  assign bus.acc_rst    = r_acc_rst;
  assign bus.acc_en     = r_acc_en;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sum    = r_out_sum;
  assign o_dbg_state    = r_state;
`ifdef VECTOR_PACKER_TIMEOUT_EN
  assign bus.err        = r_err;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
